// File: rtl/baccarat_pkg.sv
// Shared types and constants for the baccarat sequencing controller.
// Latency: n/a (types, constants and one pure function).
// Backpressure: n/a.
package baccarat_pkg;

  // Hand sequencing states, 4-bit encoding, listed in deal order.
  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_P1   = 4'd1,
    ST_D1   = 4'd2,
    ST_P2   = 4'd3,
    ST_D2   = 4'd4,
    ST_NAT  = 4'd5,
    ST_P3   = 4'd6,
    ST_BANK = 4'd7,
    ST_D3   = 4'd8,
    ST_DONE = 4'd9
  } state_e;

  // Card codes: 0 means no card, 10..13 are the zero-valued picture/ten ranks.
  localparam logic [3:0] CARD_NONE = 4'd0;
  localparam logic [3:0] CARD_TEN  = 4'd10;

  // A two-card total at or above this is a natural.
  localparam logic [3:0] NATURAL_MIN     = 4'd8;
  // Player draws on totals up to this value; the dealer uses the same cut
  // when the player stood.
  localparam logic [3:0] PLAYER_DRAW_MAX = 4'd5;

  // Point value of a card code; tens, pictures and unused codes count 0.
  function automatic logic [3:0] card_value(input logic [3:0] code);
    if ((code == CARD_NONE) || (code >= CARD_TEN)) begin
      return 4'd0;
    end
    return code;
  endfunction

endpackage

// File: rtl/dealer_draw_rule.sv
// Dealer third-card decision (punto-banco tableau).
// Latency: purely combinational.
// Backpressure: none.
module dealer_draw_rule
  import baccarat_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] pvalue,
  input  logic       player_drew,
  output logic       draw
);

  // Player stood: dealer follows the player's cut. Player drew: tableau on
  // the player's third-card value. Totals of 7 and above never draw.
  always_comb begin
    draw = 1'b0;
    if (!player_drew) begin
      draw = (dscore <= PLAYER_DRAW_MAX);
    end else begin
      case (dscore)
        4'd0, 4'd1, 4'd2: draw = 1'b1;
        4'd3:             draw = (pvalue != 4'd8);
        4'd4:             draw = (pvalue >= 4'd2) && (pvalue <= 4'd7);
        4'd5:             draw = (pvalue >= 4'd4) && (pvalue <= 4'd7);
        4'd6:             draw = (pvalue >= 4'd6) && (pvalue <= 4'd7);
        default:          draw = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/baccarat_ctrl.sv
// Baccarat hand sequencer: issues card-load strobes, applies drawing rules, lights winner.
// Latency: 6 to 9 slow_clock rising edges from reset release to DONE; one hand per reset.
// Backpressure: with DEAL_STEP_EN defined, the step input gates every advance and every load.
module baccarat_ctrl
  import baccarat_pkg::*;
(
  input  logic       slow_clock,
  input  logic       resetb,
`ifdef DEAL_STEP_EN
  input  logic       step,
`endif
  input  logic [3:0] pcard3,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       hand_done
);

  state_e     state_q, state_d;
  logic       adv;
  logic       natural;
  logic       player_drew;
  logic       dealer_draw;
  logic [3:0] pvalue;

`ifdef DEAL_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  // Any score of 8 or more ends the hand; this also absorbs out-of-range scores.
  assign natural     = (pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN);
  assign pvalue      = card_value(pcard3);
  assign player_drew = (state_q == ST_BANK);

  dealer_draw_rule u_dealer_draw_rule (
    .dscore      (dscore),
    .pvalue      (pvalue),
    .player_drew (player_drew),
    .draw        (dealer_draw)
  );

  // State register; reset returns the table to IDLE without waiting for a clock.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: fixed deal order, then the natural / player / dealer decisions.
  always_comb begin
    state_d = state_q;
    if (adv) begin
      case (state_q)
        ST_IDLE: state_d = ST_P1;
        ST_P1:   state_d = ST_D1;
        ST_D1:   state_d = ST_P2;
        ST_P2:   state_d = ST_D2;
        ST_D2:   state_d = ST_NAT;
        ST_NAT: begin
          if (natural) begin
            state_d = ST_DONE;
          end else if (pscore <= PLAYER_DRAW_MAX) begin
            state_d = ST_P3;
          end else if (dealer_draw) begin
            state_d = ST_D3;
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_P3:   state_d = ST_BANK;
        ST_BANK: state_d = dealer_draw ? ST_D3 : ST_DONE;
        ST_D3:   state_d = ST_DONE;
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Moore outputs: one load per card state (gated by adv), lights only in DONE.
  always_comb begin
    load_pcard1      = adv && (state_q == ST_P1);
    load_dcard1      = adv && (state_q == ST_D1);
    load_pcard2      = adv && (state_q == ST_P2);
    load_dcard2      = adv && (state_q == ST_D2);
    load_pcard3      = adv && (state_q == ST_P3);
    load_dcard3      = adv && (state_q == ST_D3);
    hand_done        = (state_q == ST_DONE);
    player_win_light = 1'b0;
    dealer_win_light = 1'b0;
    if (state_q == ST_DONE) begin
      player_win_light = (pscore >= dscore);
      dealer_win_light = (dscore >= pscore);
    end
  end

endmodule

// File: tb/tb_baccarat_ctrl.sv
// Directed bench for baccarat_ctrl: expected output vectors queued per step, compared after each edge.
// Vector order: {lp1, lp2, lp3, ld1, ld2, ld3, player_light, dealer_light, hand_done}.
// Step-gated checks run only when DEAL_STEP_EN is defined.
module tb_baccarat_ctrl;

  localparam logic [8:0] NONE = 9'b000000000;
  localparam logic [8:0] LP1  = 9'b100000000;
  localparam logic [8:0] LP2  = 9'b010000000;
  localparam logic [8:0] LP3  = 9'b001000000;
  localparam logic [8:0] LD1  = 9'b000100000;
  localparam logic [8:0] LD2  = 9'b000010000;
  localparam logic [8:0] LD3  = 9'b000001000;
  localparam logic [8:0] PW   = 9'b000000100;
  localparam logic [8:0] DW   = 9'b000000010;
  localparam logic [8:0] HD   = 9'b000000001;

  logic       slow_clock;
  logic       resetb;
`ifdef DEAL_STEP_EN
  logic       step;
`endif
  logic [3:0] pcard3;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light, hand_done;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  string      tag_q[$];

  wire [8:0] obs_v = {load_pcard1, load_pcard2, load_pcard3,
                      load_dcard1, load_dcard2, load_dcard3,
                      player_win_light, dealer_win_light, hand_done};

  baccarat_ctrl dut (
    .slow_clock       (slow_clock),
    .resetb           (resetb),
`ifdef DEAL_STEP_EN
    .step             (step),
`endif
    .pcard3           (pcard3),
    .pscore           (pscore),
    .dscore           (dscore),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light),
    .hand_done        (hand_done)
  );

  initial slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  task automatic compare_front();
    logic [8:0] e;
    string      t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %b required a queued expectation", obs_v);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (obs_v === e) else begin
      errors++;
      $error("FAIL %s: observed %b required %b", t, obs_v, e);
    end
  endtask

  // Queue the expectation, advance one rising edge, then compare.
  task automatic tick(input string t, input logic [8:0] e);
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge slow_clock);
    #1;
    compare_front();
  endtask

  // Queue the expectation and compare without a clock edge.
  task automatic now(input string t, input logic [8:0] e);
    exp_q.push_back(e);
    tag_q.push_back(t);
    #1;
    compare_front();
  endtask

  // Reset, release on a falling edge, then walk the fixed four-card deal.
  task automatic start_hand(input string t);
    resetb = 1'b0;
`ifdef DEAL_STEP_EN
    step = 1'b1;
`endif
    #2;
    now({t, "_reset"}, NONE);
    @(negedge slow_clock);
    resetb = 1'b1;
    now({t, "_idle"}, NONE);
    tick({t, "_p1"}, LP1);
    tick({t, "_d1"}, LD1);
    tick({t, "_p2"}, LP2);
    tick({t, "_d2"}, LD2);
  endtask

  initial begin
    resetb = 1'b0;
`ifdef DEAL_STEP_EN
    step   = 1'b1;
`endif
    pcard3 = 4'd0;
    pscore = 4'd0;
    dscore = 4'd0;
    #12;
    now("por_reset", NONE);

    // Player natural 8 vs 3: DONE on the 6th edge, player light only.
    pscore = 4'd8; dscore = 4'd3; pcard3 = 4'd0;
    start_hand("nat");
    tick("nat_nat",  NONE);
    tick("nat_done", PW | HD);
    tick("nat_hold", PW | HD);

    // Both stand 7 vs 6.
    pscore = 4'd7; dscore = 4'd6;
    start_hand("stand");
    tick("stand_nat",  NONE);
    tick("stand_done", PW | HD);

    // Player draws an 8, dealer on 3 stands.
    pscore = 4'd4; dscore = 4'd3; pcard3 = 4'd8;
    start_hand("p8");
    tick("p8_nat",  NONE);
    tick("p8_p3",   LP3);
    tick("p8_bank", NONE);
    tick("p8_done", PW | HD);
    tick("p8_hold", PW | HD);

    // Player draws a queen (value 0), dealer on 3 draws.
    pscore = 4'd4; dscore = 4'd3; pcard3 = 4'd12;
    start_hand("pq");
    tick("pq_nat",  NONE);
    tick("pq_p3",   LP3);
    tick("pq_bank", NONE);
    tick("pq_d3",   LD3);
    pscore = 4'd2; dscore = 4'd7;
    tick("pq_done", DW | HD);

    // Tie at 5: player draws a 9, dealer on 5 stands; lights dark in BANK.
    pscore = 4'd5; dscore = 4'd5; pcard3 = 4'd9;
    start_hand("tie");
    tick("tie_nat",  NONE);
    tick("tie_p3",   LP3);
    tick("tie_bank", NONE);
    tick("tie_done", PW | DW | HD);

    // Player stands on 7, dealer on 4 draws via the NAT path.
    pscore = 4'd7; dscore = 4'd4; pcard3 = 4'd0;
    start_hand("ddraw");
    tick("ddraw_nat",  NONE);
    tick("ddraw_d3",   LD3);
    tick("ddraw_done", PW | HD);

    // Out-of-range player score ends the hand as a natural.
    pscore = 4'd12; dscore = 4'd2;
    start_hand("oor");
    tick("oor_nat",  NONE);
    tick("oor_done", PW | HD);

    // Reset during P2 clears outputs without a clock; deal restarts at IDLE.
    pscore = 4'd3; dscore = 4'd3;
    resetb = 1'b0;
    #2;
    now("mid_reset", NONE);
    @(negedge slow_clock);
    resetb = 1'b1;
    tick("mid_p1", LP1);
    tick("mid_d1", LD1);
    tick("mid_p2", LP2);
    #2;
    resetb = 1'b0;
    now("mid_drop", NONE);
    @(negedge slow_clock);
    resetb = 1'b1;
    now("mid_idle", NONE);
    tick("mid_restart_p1", LP1);
    tick("mid_restart_d1", LD1);

`ifdef DEAL_STEP_EN
    // Hold step low in D1: no load, no advance; one pulse yields one load then P2.
    pscore = 4'd8; dscore = 4'd3;
    resetb = 1'b0;
    step   = 1'b1;
    #2;
    now("step_reset", NONE);
    @(negedge slow_clock);
    resetb = 1'b1;
    tick("step_p1", LP1);
    tick("step_d1", LD1);
    step = 1'b0;
    now("step_hold_now", NONE);
    for (int i = 0; i < 5; i++) begin
      tick($sformatf("step_hold_%0d", i), NONE);
    end
    step = 1'b1;
    now("step_pulse_ld1", LD1);
    tick("step_moved_p2", LP2);
    step = 1'b0;
    now("step_p2_gated", NONE);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/baccarat_ctrl.md
# baccarat_ctrl

Sequencing controller for the baccarat table: drives the six one-cycle card-load strobes into the card datapath and applies the punto-banco drawing rules to the scores it returns. It sits beside the datapath on `slow_clock`, consumes `pscore`, `dscore` and the player's third-card code, and raises the win lights when the hand is settled. One hand per reset.

## Interface
- No parameters. Shared types and constants live in the package.
- `slow_clock` in 1: FSM clock. State updates on the rising edge; the datapath samples loads on the falling edge.
- `resetb` in 1: asynchronous, active-low reset.
- `step` in 1: advance qualifier. Present only with `DEAL_STEP_EN`.
- `pcard3` in 4: player third-card code. 0 = none, 1–13 = A..K.
- `pscore` in 4: player hand score, 0–9.
- `dscore` in 4: dealer hand score, 0–9.
- `load_pcard1`, `load_pcard2`, `load_pcard3` out 1 each: player card-load strobes.
- `load_dcard1`, `load_dcard2`, `load_dcard3` out 1 each: dealer card-load strobes.
- `player_win_light` out 1: player wins. Also high on a tie.
- `dealer_win_light` out 1: dealer wins. Also high on a tie.
- `hand_done` out 1: the FSM is in DONE.

## Operation
- Reset value: every output is 0 and the state is IDLE.
- States in order: IDLE, P1, D1, P2, D2, NAT, P3, BANK, D3, DONE.
- Loads are Moore outputs. Exactly one load is high in each of P1, D1, P2, D2, P3 and D3; no load is high in any other state.
- Fixed path: IDLE→P1→D1→P2→D2→NAT.
- NAT transitions:
  - `pscore`≥8 or `dscore`≥8 (natural) → DONE.
  - Otherwise `pscore`≤5 → P3.
  - Otherwise (player stands on 6–7): `dscore`≤5 → D3, else → DONE.
- P3 → BANK.
- BANK: let v = value of `pcard3` (ranks 10–13 count as 0). The dealer draws (→D3) when:
  - `dscore` 0–2: always.
  - `dscore` 3: v≠8.
  - `dscore` 4: v in 2..7.
  - `dscore` 5: v in 4..7.
  - `dscore` 6: v in 6..7.
  - `dscore` 7: never.
  - If the dealer does not draw → DONE.
- D3 → DONE.
- DONE is absorbing until `resetb`.
- Lights are valid only in DONE and are 0 in all other states:
  - `pscore`>`dscore`: player light only.
  - `pscore`<`dscore`: dealer light only.
  - Equal scores: both lights.
- All comparisons are unsigned 4-bit.
- Input scores >9 are out of contract. The FSM must not hang on them: it treats them as a natural and goes to DONE.

## Timing
- A load asserted after rising edge N is captured by the datapath at falling edge N. The new score is valid at rising edge N+1.
- NAT and BANK exist so that decisions use scores that include the last card loaded.
- Minimum hand is 6 cycles from reset release to DONE: IDLE, P1, D1, P2, D2, NAT, then DONE.
- Maximum hand is 9 cycles: reaches DONE on the 9th rising edge.
- Reset mid-hand: all outputs drop to 0 immediately, without waiting for a clock. The next deal starts from IDLE.

## Configuration
- `DEAL_STEP_EN` defined:
  - The `step` port exists.
  - Transitions out of non-DONE states occur only on rising edges where `step`=1; with `step`=0 the state holds.
  - Load outputs are gated (state match AND `step`), so each `step` pulse produces at most one load.
- `DEAL_STEP_EN` not defined: the `step` port is absent and the FSM advances every cycle.
- Decision logic is identical in both builds.

## Structure
- Package `baccarat_pkg` holds:
  - The state enum (4-bit encoding).
  - Card-code constants (NONE=0, TEN=10).
  - Function `card_value` mapping a 4-bit code to 0–9.
  - Natural threshold 8 and player-draw threshold 5.
- Sub-module `dealer_draw_rule`: combinational; inputs `dscore`, v, player_drew; output `draw`. It is used in both NAT (player_drew=0) and BANK (player_drew=1).

## Test plan
- Player natural: after D2, `pscore`=8, `dscore`=3 → NAT→DONE. No P3/D3 load, `player_win_light`=1, `dealer_win_light`=0, `hand_done` on the 6th rising edge.
- Both stand: `pscore`=7, `dscore`=6 → NAT→DONE. Player light only, no third-card loads.
- Player draws, dealer rule: `pscore`=4 (draws), `pcard3`=8, `dscore`=3 → `load_pcard3` pulses once, BANK→DONE, `load_dcard3` stays 0. Repeat with `pcard3`=12 (v=0) → `load_dcard3` pulses once in D3.
- Tie: final `pscore`=`dscore`=5 → both lights 1 in DONE, both 0 the cycle before.
- Reset mid-deal: assert `resetb`=0 during P2 → all loads and lights read 0 immediately. After release the sequence restarts at IDLE→P1.
- `DEAL_STEP_EN` build: hold `step`=0 for 5 cycles in D1 → state frozen, `load_dcard1`=0 throughout. One `step` pulse → exactly one `load_dcard1`, and the FSM moves to P2.
